uart_fifo_thr: RTL and testbench
================================

# uart_fifo_thr

Parametrised synchronous FIFO for the UART TX/RX data paths, successor to the basic UART FIFO. It adds configurable depth and width, a first-word-fall-through (FWFT) mode, programmable almost-full and almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags and a synchronous flush. It sits between the UART shift engines and the register interface, and supplies the trigger-level conditions used for interrupt generation.

## Interface

- DATA_SIZE, 8: data word width in bits.
- SIZE_FIFO, 16: depth in words; power of two, ≥ 2.
- ADDR_WIDTH, $clog2(SIZE_FIFO): pointer width (derived; do not override).
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.

- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents and flags.
- clr_err  input  1  clears overflow/underflow.
- data_in  input  DATA_SIZE  write data.
- write  input  1  write request.
- read  input  1  read/pop request.
- af_thresh  input  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold.
- data_out  output  DATA_SIZE  read data.
- full  output  1  level == SIZE_FIFO.
- empty  output  1  level == 0.
- almost_full  output  1  level ≥ af_thresh.
- almost_empty  output  1  level ≤ ae_thresh.
- level  output  ADDR_WIDTH+1  stored word count, 0..SIZE_FIFO.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was made while empty.

## Operation

- Storage: SIZE_FIFO × DATA_SIZE array. wr_ptr/rd_ptr are ADDR_WIDTH bits and wrap naturally from SIZE_FIFO-1 to 0. Level is a registered counter.
- Write accepted (wr_en) when write && (!full || read). A write while full with a simultaneous read is accepted, and level is unchanged.
- Read accepted (rd_en) when read && !empty. On empty with simultaneous write, only the write takes effect.
- Level update: +1 on wr_en only, −1 on rd_en only, unchanged on both or neither.
- FWFT=0: on rd_en, data_out ← mem[rd_ptr] at the clock edge. Otherwise data_out holds.
- FWFT=1: data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_en pops the head word.
- overflow set on write && full && !read. underflow set on read && empty. Both stay set until clr_err, flush or reset. Set has priority over clr_err in the same cycle.
- flush: pointers, level, data_out and both sticky flags go to 0. flush overrides write/read in the same cycle. Array contents are not cleared.
- full, empty, almost_full and almost_empty are combinational from the level register. The thresholds are sampled live, not latched.
- Threshold values outside 0..SIZE_FIFO are legal; the comparisons are plain unsigned.

## Timing

- Reset values: level 0, empty 1, full 0, almost_empty 1, almost_full = (af_thresh == 0), overflow 0, underflow 0, data_out 0. Both pointers are 0.
- Reset overrides flush, write and read. Reset mid-stream discards all contents at that edge.
- Write-to-empty deassertion: empty falls at the edge where the write is captured.
- FWFT=1: data_out is valid in the same cycle that empty falls.
- FWFT=0 read latency: data_out is valid one cycle after the edge that samples read.
- Flags, level and sticky bits all change only on rising clk edges, with no extra pipeline delay.

## Test plan

1. FWFT=0, SIZE_FIFO=8: reset, then write 0x6C, 0xAF, 0x64 on consecutive cycles, then read three times -> data_out shows 0x6C, 0xAF, 0x64 after successive edges; level goes 3→2→1→0; empty=1 after the third read edge.
2. Write 8 words 0x01..0x08 -> full=1, level=8. Then write 0xFF alone -> dropped, overflow=1, level stays 8. Read 8 -> 0x01..0x08 in order and no 0xFF. overflow stays 1 until a clr_err pulse clears it.
3. While full, assert read and write 0x55 in the same cycle -> level stays 8, full stays 1, overflow stays 0. After draining, 0x55 is the last word out.
4. af_thresh=6, ae_thresh=2, write one word per cycle from empty -> almost_empty falls on the edge where level goes 2→3; almost_full rises on the edge where level goes 5→6. The reverse transitions occur while reading back.
5. Read while empty -> underflow=1, level stays 0, data_out unchanged. Read+write 0x3C on empty -> level=1, underflow=1, 0x3C is retained.
6. FWFT=1: write 0xA5 into empty -> data_out=0xA5 in the cycle after the write edge. Then fill to level 5 and assert flush together with write and read -> next edge gives level=0, empty=1, data_out=0, with no write or read performed.

Source files
------------

// File: rtl/uart_fifo_thr.sv
// Synchronous FIFO for the UART TX/RX data paths. It has optional first-word-fall-through
// reads, programmable almost-full/almost-empty thresholds, a fill level and sticky error flags.
module uart_fifo_thr #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE_FIFO),
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(SIZE_FIFO);

  logic [DATA_SIZE-1:0]  mem [SIZE_FIFO];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_en, rd_en;

  // Status flags come straight from the level register, and the thresholds are read live.
  assign full         = (level_q == DEPTH);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is allowed when a read frees the head slot in the same cycle.
  assign wr_en = write && (!full || read);
  assign rd_en = read && !empty;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
        2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
        default: level_d = level_q;
      endcase
      // A new error event wins over a clear in the same cycle.
      if (write && full && !read) overflow_d = 1'b1;
      else if (clr_err)           overflow_d = 1'b0;
      if (read && empty)          underflow_d = 1'b1;
      else if (clr_err)           underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is not reset. The pointers and the level decide which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_en) mem[wr_ptr_q] <= data_in;
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;

    always_comb begin
      data_out_d = data_out_q;
      if (flush)      data_out_d = '0;
      else if (rd_en) data_out_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (reset) data_out_q <= '0;
      else       data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
  end

endmodule

// File: tb/tb_uart_fifo_thr.sv
// Directed bench for uart_fifo_thr. A registered-read instance and a fall-through instance share
// one stimulus stream. A queue model checks them on every cycle, and literal checks pin the model.
module tb_uart_fifo_thr;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset, flush, clr_err, write, read;
  logic [DW-1:0] data_in;
  logic [AW:0]   af_thresh, ae_thresh;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   r_lvl, f_lvl;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dreg = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  uart_fifo_thr #(.DATA_SIZE(DW), .SIZE_FIFO(DEPTH), .FWFT(1'b0)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .data_in(data_in),
    .write(write), .read(read), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(r_dout), .full(r_full), .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .level(r_lvl), .overflow(r_ovf), .underflow(r_unf));

  uart_fifo_thr #(.DATA_SIZE(DW), .SIZE_FIFO(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .data_in(data_in),
    .write(write), .read(read), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .level(f_lvl), .overflow(f_ovf), .underflow(f_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model works at the queue level: a word is dropped, accepted or popped by rule.
  always @(posedge clk) begin
    if (reset || flush) begin
      m_q.delete();
      m_dreg = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (write && was_full && !read) m_ovf = 1'b1;
      else if (clr_err)               m_ovf = 1'b0;
      if (read && was_empty)          m_unf = 1'b1;
      else if (clr_err)               m_unf = 1'b0;
      if (read && !was_empty) m_dreg = m_q.pop_front();
      if (write && (!was_full || read)) m_q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int            lvl;
      logic [DW-1:0] head;
      lvl  = m_q.size();
      head = (lvl > 0) ? m_q[0] : '0;
      check("r_level", 32'(r_lvl), 32'(lvl));
      check("f_level", 32'(f_lvl), 32'(lvl));
      check("r_full",  32'(r_full),  32'(lvl == DEPTH));
      check("f_full",  32'(f_full),  32'(lvl == DEPTH));
      check("r_empty", 32'(r_empty), 32'(lvl == 0));
      check("f_empty", 32'(f_empty), 32'(lvl == 0));
      check("r_afull", 32'(r_af), 32'(lvl >= int'(af_thresh)));
      check("f_afull", 32'(f_af), 32'(lvl >= int'(af_thresh)));
      check("r_aempty", 32'(r_ae), 32'(lvl <= int'(ae_thresh)));
      check("f_aempty", 32'(f_ae), 32'(lvl <= int'(ae_thresh)));
      check("r_ovf", 32'(r_ovf), 32'(m_ovf));
      check("f_ovf", 32'(f_ovf), 32'(m_ovf));
      check("r_unf", 32'(r_unf), 32'(m_unf));
      check("f_unf", 32'(f_unf), 32'(m_unf));
      check("r_dout", 32'(r_dout), 32'(m_dreg));
      check("f_dout", 32'(f_dout), 32'(head));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
    write   = w;
    read    = r;
    data_in = d;
    tick();
    write   = 1'b0;
    read    = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    drive(1'b1, 1'b0, d);
  endtask

  task automatic rd();
    drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; clr_err = 1'b0; write = 1'b0; read = 1'b0;
    data_in = '0; af_thresh = 4'd0; ae_thresh = 4'd2;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_level", 32'(r_lvl), 32'd0);
    check("rst_empty", 32'(r_empty), 32'd1);
    check("rst_full", 32'(r_full), 32'd0);
    check("rst_aempty", 32'(r_ae), 32'd1);
    check("rst_afull_thr0", 32'(r_af), 32'd1);
    check("rst_ovf", 32'(r_ovf), 32'd0);
    check("rst_unf", 32'(r_unf), 32'd0);
    check("rst_r_dout", 32'(r_dout), 32'h00);
    check("rst_f_dout", 32'(f_dout), 32'h00);
    af_thresh = 4'd6;
    #1;
    check("rst_afull_thr6", 32'(r_af), 32'd0);
    reset = 1'b0;

    // Basic in-order write and read
    wr(8'h6C);
    check("t1_empty_falls", 32'(r_empty), 32'd0);
    check("t1_fwft_same_cycle", 32'(f_dout), 32'h6C);
    wr(8'hAF);
    wr(8'h64);
    check("t1_level3", 32'(r_lvl), 32'd3);
    rd(); check("t1_rd0", 32'(r_dout), 32'h6C); check("t1_lvl2", 32'(r_lvl), 32'd2);
    rd(); check("t1_rd1", 32'(r_dout), 32'hAF); check("t1_lvl1", 32'(r_lvl), 32'd1);
    rd(); check("t1_rd2", 32'(r_dout), 32'h64); check("t1_lvl0", 32'(r_lvl), 32'd0);
    check("t1_empty", 32'(r_empty), 32'd1);

    // Fill, overflow, drain, clear error
    for (int i = 1; i <= 8; i++) wr(8'(i));
    check("t2_full", 32'(r_full), 32'd1);
    check("t2_level8", 32'(r_lvl), 32'd8);
    wr(8'hFF);
    check("t2_ovf", 32'(r_ovf), 32'd1);
    check("t2_level_held", 32'(r_lvl), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      rd();
      check("t2_drain", 32'(r_dout), 32'(i));
    end
    check("t2_ovf_sticky", 32'(r_ovf), 32'd1);
    clr_err = 1'b1; idle(); clr_err = 1'b0;
    check("t2_ovf_clr", 32'(r_ovf), 32'd0);

    // Simultaneous read and write while full
    for (int i = 0; i < 8; i++) wr(8'(8'h11 + i));
    drive(1'b1, 1'b1, 8'h55);
    check("t3_level", 32'(r_lvl), 32'd8);
    check("t3_full", 32'(r_full), 32'd1);
    check("t3_no_ovf", 32'(r_ovf), 32'd0);
    check("t3_head", 32'(r_dout), 32'h11);
    for (int i = 0; i < 7; i++) begin
      rd();
      check("t3_drain", 32'(r_dout), 32'(8'h12 + i));
    end
    rd();
    check("t3_last_55", 32'(r_dout), 32'h55);

    // Threshold crossings with af=6 and ae=2
    wr(8'h21); wr(8'h22);
    check("t4_ae_at2", 32'(r_ae), 32'd1);
    wr(8'h23);
    check("t4_ae_at3", 32'(r_ae), 32'd0);
    wr(8'h24); wr(8'h25);
    check("t4_af_at5", 32'(r_af), 32'd0);
    wr(8'h26);
    check("t4_af_at6", 32'(r_af), 32'd1);
    rd();
    check("t4_af_back5", 32'(r_af), 32'd0);
    rd(); rd();
    check("t4_ae_back3", 32'(r_ae), 32'd0);
    rd();
    check("t4_ae_back2", 32'(r_ae), 32'd1);
    rd(); rd();
    check("t4_drained", 32'(r_dout), 32'h26);

    // Underflow handling
    rd();
    check("t5_unf", 32'(r_unf), 32'd1);
    check("t5_level0", 32'(r_lvl), 32'd0);
    check("t5_dout_held", 32'(r_dout), 32'h26);
    drive(1'b1, 1'b1, 8'h3C);
    check("t5_level1", 32'(r_lvl), 32'd1);
    check("t5_unf_kept", 32'(r_unf), 32'd1);
    check("t5_dout_still", 32'(r_dout), 32'h26);
    check("t5_fwft_3c", 32'(f_dout), 32'h3C);
    rd();
    check("t5_rd_3c", 32'(r_dout), 32'h3C);
    clr_err = 1'b1; rd(); clr_err = 1'b0;
    check("t5_set_beats_clr", 32'(r_unf), 32'd1);
    clr_err = 1'b1; idle(); clr_err = 1'b0;
    check("t5_unf_clr", 32'(r_unf), 32'd0);

    // Fall-through output and flush priority
    rd();
    wr(8'hA5);
    check("t6_fwft_a5", 32'(f_dout), 32'hA5);
    wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
    check("t6_level5", 32'(f_lvl), 32'd5);
    check("t6_head_a5", 32'(f_dout), 32'hA5);
    flush = 1'b1; drive(1'b1, 1'b1, 8'hEE); flush = 1'b0;
    check("t6_flush_level", 32'(f_lvl), 32'd0);
    check("t6_flush_empty", 32'(f_empty), 32'd1);
    check("t6_flush_fdout", 32'(f_dout), 32'h00);
    check("t6_flush_rdout", 32'(r_dout), 32'h00);
    check("t6_flush_unf", 32'(r_unf), 32'd0);

    // Out-of-range thresholds, then reset in mid-stream
    af_thresh = 4'd15; ae_thresh = 4'd15;
    for (int i = 0; i < 8; i++) wr(8'(8'hC0 + i));
    check("t7_full", 32'(r_full), 32'd1);
    check("t7_af_oor", 32'(r_af), 32'd0);
    check("t7_ae_oor", 32'(r_ae), 32'd1);
    reset = 1'b1; wr(8'hDD); reset = 1'b0;
    check("t7_rst_level", 32'(r_lvl), 32'd0);
    check("t7_rst_empty", 32'(r_empty), 32'd1);
    af_thresh = 4'd6; ae_thresh = 4'd2;
    wr(8'h77);
    check("t7_fwft_77", 32'(f_dout), 32'h77);
    rd();
    check("t7_rd_77", 32'(r_dout), 32'h77);
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
